// File: rtl/unary_word_expander.sv
// Expands a binary count N into a stream of 8-bit thermometer words whose popcounts sum to N.
// Inverse of the 8-input popcount compressor; valid/ready on both sides, one-cycle latency.
module unary_word_expander #(
   parameter int CNT_W  = 8,
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CNT_W-1:0]  in_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic              out_last,
   output logic              busy
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic             xfer;
   logic             accept;
   logic [3:0]       load_k;
   logic [3:0]       rem_k;

   // Number of ones that fit in the next word: min(n, 8).
   function automatic logic [3:0] chunk(input logic [CNT_W-1:0] n);
      return (n >= CNT_W'(8)) ? 4'd8 : n[3:0];
   endfunction

   function automatic logic [WORD_W-1:0] thermo(input logic [3:0] k);
      logic [WORD_W-1:0] ones;
      ones = '1;
      return ones >> (4'd8 - k);
   endfunction

   assign xfer   = out_valid && out_ready;
   // Only combinational path: the final word leaving frees the block for a new count in the same cycle.
   assign in_ready = !reset && ((state == IDLE) || (xfer && out_last));
   assign accept   = in_valid && in_ready;
   assign load_k   = chunk(in_count);
   assign rem_k    = chunk(rem);

   // NOTE: state and registered outputs use non-blocking assignments so every
   // update in this block sees the pre-edge values, matching the hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rem       <= '0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (accept) begin
         state     <= EMIT;
         out_valid <= 1'b1;
         busy      <= 1'b1;
         out_word  <= thermo(load_k);
         out_last  <= (in_count <= CNT_W'(8));
         rem       <= in_count - CNT_W'(load_k);
      end else if (xfer && out_last) begin
         state     <= IDLE;
         rem       <= '0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (xfer) begin
         out_word <= thermo(rem_k);
         out_last <= (rem <= CNT_W'(8));
         rem      <= rem - CNT_W'(rem_k);
      end
   end

endmodule

// File: tb/tb_unary_word_expander.sv
// Self-checking bench for unary_word_expander: directed scenarios plus a scoreboarded
// random round-trip that popcounts every transferred word back into N.
module tb_unary_word_expander;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_word;
   logic       out_last;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] w;
      logic       l;
   } exp_t;

   exp_t exp_q[$];
   int   n_q[$];
   int   pend[$];
   bit   pat[$];
   int   pat_idx;

   int   xfers, bubbles, stall_cycles, b2b_hits, cycles;

   unary_word_expander #(.CNT_W(8), .WORD_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Expected word stream for one count, built bit by bit.
   function automatic void push_expected(input int n);
      int nw;
      nw = (n == 0) ? 1 : (n + 7) / 8;
      for (int i = 0; i < nw; i++) begin
         exp_t e;
         int   ones;
         ones = n - 8 * i;
         if (ones > 8) ones = 8;
         e.w = '0;
         for (int b = 0; b < ones; b++) e.w[b] = 1'b1;
         e.l = (i == nw - 1);
         exp_q.push_back(e);
      end
      n_q.push_back(n);
   endfunction

   // Presents every count in pend back-to-back and scoreboards the output stream.
   task automatic run_engine(input string name, input bit rnd, input int budget);
      int         sum;
      int         words;
      int         exp_words;
      int         n;
      bit         stalled;
      bit         prev_acc;
      logic [7:0] prev_w;
      logic       prev_l;
      exp_t       e;
      sum = 0; words = 0; stalled = 0; prev_acc = 0; prev_w = '0; prev_l = 0;
      xfers = 0; bubbles = 0; stall_cycles = 0; b2b_hits = 0; cycles = 0; pat_idx = 0;
      while ((pend.size() > 0 || exp_q.size() > 0) && cycles < budget) begin
         in_valid = (pend.size() > 0);
         in_count = in_valid ? 8'(pend[0]) : 8'($urandom);
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         else if (pat.size() > 0) out_ready = pat[pat_idx % pat.size()];
         else out_ready = 1'b1;
         #1;
         if (stalled) begin
            stall_cycles++;
            n_checks++;
            if (out_valid !== 1'b1 || out_word !== prev_w || out_last !== prev_l) begin
               n_fail++;
               $display("FAIL %s hold: got v=%b w=%h l=%b, required v=1 w=%h l=%b",
                        name, out_valid, out_word, out_last, prev_w, prev_l);
            end
         end
         if (out_valid === 1'b1) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy: got %b, required 1", name, busy);
            end
            if (!(out_ready && out_last)) begin
               n_checks++;
               if (in_ready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s in_ready_mid: got %b, required 0", name, in_ready);
               end
            end
         end
         if (out_valid !== 1'b1 && exp_q.size() > 0 && !prev_acc) bubbles++;
         if (out_valid === 1'b1 && out_ready) begin
            xfers++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_word: got w=%h, required no word", name, out_word);
            end else begin
               e = exp_q.pop_front();
               if (out_word !== e.w || out_last !== e.l) begin
                  n_fail++;
                  $display("FAIL %s word: got w=%h l=%b, required w=%h l=%b",
                           name, out_word, out_last, e.w, e.l);
               end
            end
            sum += $countones(out_word);
            words++;
            if (out_last === 1'b1) begin
               if (in_valid && in_ready) b2b_hits++;
               n = (n_q.size() > 0) ? n_q.pop_front() : -1;
               exp_words = (n == 0) ? 1 : (n + 7) / 8;
               n_checks++;
               if (sum != n || words != exp_words) begin
                  n_fail++;
                  $display("FAIL %s round_trip: got sum=%0d words=%0d, required sum=%0d words=%0d",
                           name, sum, words, n, exp_words);
               end
               sum = 0;
               words = 0;
            end
         end
         prev_acc = in_valid && (in_ready === 1'b1);
         if (prev_acc) push_expected(pend.pop_front());
         stalled = (out_valid === 1'b1) && !out_ready;
         prev_w  = out_word;
         prev_l  = out_last;
         if (out_valid === 1'b1) pat_idx++;
         cyc();
         cycles++;
      end
      n_checks++;
      if (cycles >= budget) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d cycles, required < %0d", name, cycles, budget);
      end
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_word !== 8'h00 ||
          out_last !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s idle_after: got v=%b b=%b w=%h l=%b rdy=%b, required 0 0 00 0 1",
                  name, out_valid, busy, out_word, out_last, in_ready);
      end
      n_checks++;
      if (bubbles != 0) begin
         n_fail++;
         $display("FAIL %s bubbles: got %0d, required 0", name, bubbles);
      end
      exp_q.delete();
      n_q.delete();
      pend.delete();
      pat.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_count = 8'd13; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_checks++;
         if (out_valid !== 1'b0 || out_word !== 8'h00 || out_last !== 1'b0 ||
             busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b w=%h l=%b b=%b rdy=%b, required all 0",
                     out_valid, out_word, out_last, busy, in_ready);
         end
      end
      reset = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_after: got %b, required 1", in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_word: got v=%b b=%b, required 0 0", out_valid, busy);
         end
      end
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_count = 8'd13; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_accept: got in_ready=%b, required 1", in_ready);
      end
      cyc();
      in_valid = 1'b0; in_count = 8'd200;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== 8'hFF || out_last !== 1'b0 ||
          busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_word0: got v=%b w=%h l=%b b=%b rdy=%b, required 1 ff 0 1 0",
                  out_valid, out_word, out_last, busy, in_ready);
      end
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== 8'h1F || out_last !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_word1: got v=%b w=%h l=%b rdy=%b, required 1 1f 1 1",
                  out_valid, out_word, out_last, in_ready);
      end
      cyc();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_word !== 8'h00) begin
         n_fail++;
         $display("FAIL single_done: got v=%b b=%b w=%h, required 0 0 00", out_valid, busy, out_word);
      end
   endtask

   task automatic test_zero_multiples();
      pend = '{0, 8, 16};
      run_engine("zero_mult", 1'b0, 50);
      n_checks++;
      if (xfers != 4) begin
         n_fail++;
         $display("FAIL zero_mult_xfers: got %0d, required 4", xfers);
      end
   endtask

   task automatic test_backpressure();
      pend = '{20};
      pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run_engine("backpressure", 1'b0, 50);
      n_checks++;
      if (xfers != 3 || stall_cycles != 3) begin
         n_fail++;
         $display("FAIL backpressure_counts: got xfers=%0d stalls=%0d, required 3 3", xfers, stall_cycles);
      end
   endtask

   task automatic test_back_to_back();
      pend = '{3, 9};
      run_engine("back_to_back", 1'b0, 50);
      n_checks++;
      if (xfers != 3 || b2b_hits != 1 || cycles != 4) begin
         n_fail++;
         $display("FAIL back_to_back_timing: got xfers=%0d hits=%0d cycles=%0d, required 3 1 4",
                  xfers, b2b_hits, cycles);
      end
   endtask

   task automatic test_round_trip();
      pend.push_back(255);
      for (int i = 0; i < 500; i++) pend.push_back(int'($urandom_range(0, 255)));
      pend.push_back(0);
      pend.push_back(255);
      run_engine("round_trip", 1'b1, 60000);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
      #2;
      test_reset();
      test_single();
      test_zero_multiples();
      test_backpressure();
      test_back_to_back();
      test_round_trip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
